apb_uart_par: RTL and testbench
===============================

APB_UART_PAR -- requirements
Module: apb_uart_par

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8, TX/RX FIFO entries (power of 2, 4..64).
REQ-002 SHALL provide parameter DIV_RST, default 16'd868, reset value of the divisor.
REQ-003 SHALL have the following ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-high.
- apb_psel / apb_penable / apb_pwrite  in  1 each  APB control.
- apb_paddr  in  5  byte address.
- apb_pwdata  in  32  write data.
- apb_prdata  out  32  read data.
- apb_pready  out  1  always 1 (zero-wait).
- apb_pslverr  out  1  error response.
- uart_txd  out  1  serial transmit; idle high.
- uart_rxd  in  1  serial receive; asynchronous.
- txwm / rxwm / rxerr  out  1 each  interrupt = ip & ie per bit.

Function
REQ-004 SHALL use this register map:
- 0x00 txdata: W [7:0] push; R bit31 full.
- 0x04 rxdata: R [7:0] data, bit31 empty, bit30 parity err, bit29 frame err.
- 0x08 txctrl: bit0 txen, bit1 nstop (0=1 stop, 1=2 stop), [3:2] parity, [CW-1+16:16] txcnt.
- 0x0C rxctrl: bit0 rxen, [3:2] parity, [CW-1+16:16] rxcnt.
- 0x10 ie: bit0 txwm, bit1 rxwm, bit2 rxerr.
- 0x14 ip: bit0 txwm, bit1 rxwm, bit2 rxerr; W1C on bit2 only.
- 0x18 div: [15:0].
- CW = log2(FIFO_DEPTH)+1.
REQ-005 Parity encoding SHALL be: 00 none, 01 even, 10 odd, 11 none.
REQ-006 Writes SHALL commit on the clk edge where psel&penable&pwrite.
REQ-007 prdata SHALL be combinational while psel&penable&!pwrite, else 0.
REQ-008 pslverr SHALL assert in the access phase for paddr>0x18 or paddr[1:0]!=0; the access has no effect.
REQ-009 A txdata write while full SHALL be dropped.
REQ-010 An rxdata read SHALL pop one entry when not empty; a read while empty returns empty=1, data 0, and no pop.
REQ-011 ip.txwm SHALL equal (tx count < txcnt); ip.rxwm SHALL equal (rx count > rxcnt).
REQ-012 ip.rxerr SHALL be sticky, set on parity error, frame error or RX overrun; set wins over a simultaneous W1C.
REQ-013 Bit period SHALL be div+1 clk cycles; div is sampled at each frame start, so mid-frame writes affect only the next frame.
REQ-014 TX FSM SHALL be IDLE->START->DATA(8 bits, LSB first)->PARITY (skipped if none)->STOP (1 or 2 bits)->IDLE.
REQ-015 TX SHALL leave IDLE only if txen=1 and the FIFO is not empty; the pop occurs on the START entry cycle.
REQ-016 Clearing txen mid-frame SHALL complete the current frame and then halt.
REQ-017 RX SHALL pass uart_rxd through a 2-flop synchronizer and start on a falling edge in IDLE when rxen=1.
REQ-018 RX SHALL re-sample the start bit at (div+1)/2 cycles; if high, it returns to IDLE without a push.
REQ-019 RX FSM SHALL be IDLE->START->DATA->PARITY (optional)->STOP->IDLE, sampling each bit mid-period.
REQ-020 A parity mismatch SHALL set that entry's perr; stop bit=0 SHALL set ferr; the entry is still pushed.
REQ-021 On push while the RX FIFO is full (with no pop the same cycle), the data SHALL be dropped and rxerr set.
REQ-022 Clearing rxen SHALL abort the RX frame immediately, returning to IDLE with no push.
REQ-023 The FIFOs SHALL accept simultaneous push and pop at full or empty without corrupting count.

Reset
REQ-024 Reset values: uart_txd=1; FSMs IDLE; FIFOs empty; txctrl, rxctrl, ie = 0; ip.rxerr=0; div=DIV_RST; interrupt outputs 0; pslverr=0; prdata=0.

Structure
REQ-025 A shared package apb_uart_par_pkg SHALL hold the register offsets, the parity enum, the TX/RX state enums and the register field structs.
REQ-026 A sub-module uart_fifo (parameter WIDTH, DEPTH; push, pop, full, empty, count) SHALL be instantiated for TX (WIDTH 8) and RX (WIDTH 10).

Verification
REQ-027 Loopback (txd->rxd), div=86, parity none, txcnt=rxcnt=4: 9 random bytes sent and all read back equal; txwm ip=1 at 4 queued, 0 at 5; txdata.full=1 at 8 queued.
REQ-028 Even parity on TX and odd parity on RX, send 0xA5 -> rxdata=0xA5 with bit30=1, ip.rxerr=1, rxerr output high with ie.rxerr=1; a W1C to ip bit2 clears it.
REQ-029 With rxen=1 and the FIFO never read, send FIFO_DEPTH+1 bytes -> count stays FIFO_DEPTH, the first FIFO_DEPTH bytes are intact, and rxerr is set.
REQ-030 Drive rxd low for only div/4 cycles -> no push, RX FSM back in IDLE; drive stop bit=0 on 0x3C -> entry 0x3C with ferr=1.
REQ-031 Access 0x1C and 0x02 -> pslverr=1 and no register changes; assert rst_b mid-TX-frame -> uart_txd=1 and all registers at reset values the next cycle.

Source files
------------

// File: rtl/apb_uart_par_pkg.sv
// Shared definitions for the APB UART: register offsets, parity and FSM
// encodings, register field layouts and the parity helper.
package apb_uart_par_pkg;

   localparam logic [4:0] ADDR_TXDATA = 5'h00;
   localparam logic [4:0] ADDR_RXDATA = 5'h04;
   localparam logic [4:0] ADDR_TXCTRL = 5'h08;
   localparam logic [4:0] ADDR_RXCTRL = 5'h0C;
   localparam logic [4:0] ADDR_IE     = 5'h10;
   localparam logic [4:0] ADDR_IP     = 5'h14;
   localparam logic [4:0] ADDR_DIV    = 5'h18;

   // Widest watermark field (FIFO_DEPTH 64 -> 7 bits); narrower configs zero-extend.
   localparam int CNT_MAX_W = 7;

   typedef enum logic [1:0] {
      PAR_NONE     = 2'b00,
      PAR_EVEN     = 2'b01,
      PAR_ODD      = 2'b10,
      PAR_NONE_ALT = 2'b11
   } parity_e;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

   typedef struct packed {
      logic [CNT_MAX_W-1:0] cnt;
      parity_e              par;
      logic                 nstop;
      logic                 en;
   } txctrl_t;

   typedef struct packed {
      logic [CNT_MAX_W-1:0] cnt;
      parity_e              par;
      logic                 en;
   } rxctrl_t;

   typedef struct packed {
      logic rxerr;
      logic rxwm;
      logic txwm;
   } irq_t;

   typedef struct packed {
      logic       perr;
      logic       ferr;
      logic [7:0] data;
   } rx_entry_t;

   function automatic logic par_used(input parity_e p);
      return (p == PAR_EVEN) || (p == PAR_ODD);
   endfunction

   // Parity bit that goes on the wire for a given byte.
   function automatic logic par_bit(input logic [7:0] d, input parity_e p);
      return (p == PAR_ODD) ? ~(^d) : (^d);
   endfunction

endpackage

// File: rtl/apb_uart_par_fifo.sv
// Synchronous show-ahead FIFO; push at full is accepted only when a pop
// frees the slot in the same cycle, pop at empty is ignored.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_count;
   logic             w_do_push, w_do_pop;

   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rdata     = r_mem[r_rptr];
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | pop);

   // Storage array, no reset needed.
   always_ff @(posedge clk)
      if (w_do_push) r_mem[r_wptr] <= wdata;

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end

endmodule

// File: rtl/apb_uart_par.sv
// APB-attached UART with TX/RX FIFOs, programmable parity/stop bits,
// watermark and error interrupts.
module apb_uart_par
   import apb_uart_par_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RST    = 16'd868
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        apb_psel,
   input  logic        apb_penable,
   input  logic        apb_pwrite,
   input  logic [4:0]  apb_paddr,
   input  logic [31:0] apb_pwdata,
   output logic [31:0] apb_prdata,
   output logic        apb_pready,
   output logic        apb_pslverr,
   output logic        uart_txd,
   input  logic        uart_rxd,
   output logic        txwm,
   output logic        rxwm,
   output logic        rxerr
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // ---------------- APB decode ----------------
   logic w_acc, w_err, w_wr, w_rd, w_unused;
   assign w_acc       = apb_psel & apb_penable;
   assign w_err       = w_acc & ((apb_paddr > ADDR_DIV) | (apb_paddr[1:0] != 2'b00));
   assign w_wr        = w_acc &  apb_pwrite & ~w_err;
   assign w_rd        = w_acc & ~apb_pwrite & ~w_err;
   assign apb_pready  = 1'b1;
   assign apb_pslverr = w_err;
   assign w_unused    = ^apb_pwdata;

   txctrl_t     r_txctrl;
   rxctrl_t     r_rxctrl;
   irq_t        r_ie, w_ip;
   logic [15:0] r_div;
   logic        r_rxerr;

   // ---------------- FIFOs ----------------
   logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic [7:0]    w_tx_rdata;
   logic [CW-1:0] w_tx_count;
   logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ovf;
   rx_entry_t     w_rx_entry, w_rx_head;
   logic [CW-1:0] w_rx_count;

   assign w_tx_push = w_wr & (apb_paddr == ADDR_TXDATA) & ~w_tx_full;
   assign w_rx_pop  = w_rd & (apb_paddr == ADDR_RXDATA) & ~w_rx_empty;
   assign w_rx_ovf  = w_rx_push & w_rx_full & ~w_rx_pop;

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_b(rst_b), .push(w_tx_push), .wdata(apb_pwdata[7:0]),
      .pop(w_tx_pop), .rdata(w_tx_rdata), .full(w_tx_full), .empty(w_tx_empty),
      .count(w_tx_count));

   uart_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_b(rst_b), .push(w_rx_push), .wdata(w_rx_entry),
      .pop(w_rx_pop), .rdata(w_rx_head), .full(w_rx_full), .empty(w_rx_empty),
      .count(w_rx_count));

   // ---------------- Registers ----------------
   // Control register writes.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) begin
         r_txctrl <= '0;
         r_rxctrl <= '0;
         r_ie     <= '0;
         r_div    <= DIV_RST;
      end else if (w_wr) begin
         case (apb_paddr)
            ADDR_TXCTRL: r_txctrl <= '{cnt: CNT_MAX_W'(apb_pwdata[16 +: CW]),
                                       par: parity_e'(apb_pwdata[3:2]),
                                       nstop: apb_pwdata[1], en: apb_pwdata[0]};
            ADDR_RXCTRL: r_rxctrl <= '{cnt: CNT_MAX_W'(apb_pwdata[16 +: CW]),
                                       par: parity_e'(apb_pwdata[3:2]),
                                       en: apb_pwdata[0]};
            ADDR_IE:     r_ie     <= irq_t'(apb_pwdata[2:0]);
            ADDR_DIV:    r_div    <= apb_pwdata[15:0];
            default:     ;
         endcase
      end

   // Sticky RX error; a new error event beats a same-cycle W1C.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b)
         r_rxerr <= 1'b0;
      else if ((w_rx_push & (w_rx_entry.perr | w_rx_entry.ferr)) | w_rx_ovf)
         r_rxerr <= 1'b1;
      else if (w_wr && (apb_paddr == ADDR_IP) && apb_pwdata[2])
         r_rxerr <= 1'b0;

   assign w_ip  = '{rxerr: r_rxerr,
                    rxwm:  (CNT_MAX_W'(w_rx_count) > r_rxctrl.cnt),
                    txwm:  (CNT_MAX_W'(w_tx_count) < r_txctrl.cnt)};
   assign txwm  = w_ip.txwm  & r_ie.txwm;
   assign rxwm  = w_ip.rxwm  & r_ie.rxwm;
   assign rxerr = w_ip.rxerr & r_ie.rxerr;

   // Read data mux, zero outside a valid read access phase.
   always_comb begin
      apb_prdata = '0;
      if (w_rd) begin
         case (apb_paddr)
            ADDR_TXDATA: apb_prdata[31] = w_tx_full;
            ADDR_RXDATA:
               if (w_rx_empty) apb_prdata[31] = 1'b1;
               else begin
                  apb_prdata[30]  = w_rx_head.perr;
                  apb_prdata[29]  = w_rx_head.ferr;
                  apb_prdata[7:0] = w_rx_head.data;
               end
            ADDR_TXCTRL: apb_prdata[22:0] = {r_txctrl.cnt, 12'b0, r_txctrl.par,
                                             r_txctrl.nstop, r_txctrl.en};
            ADDR_RXCTRL: apb_prdata[22:0] = {r_rxctrl.cnt, 12'b0, r_rxctrl.par,
                                             1'b0, r_rxctrl.en};
            ADDR_IE:     apb_prdata[2:0]  = r_ie;
            ADDR_IP:     apb_prdata[2:0]  = w_ip;
            ADDR_DIV:    apb_prdata[15:0] = r_div;
            default:     ;
         endcase
      end
   end

   // ---------------- TX ----------------
   tx_state_e   r_tx_state, w_tx_state_n;
   logic [15:0] r_tx_baud, w_tx_baud_n, r_tx_div, w_tx_div_n;
   logic [7:0]  r_tx_shift, w_tx_shift_n;
   logic [2:0]  r_tx_bit, w_tx_bit_n;
   logic        r_tx_stop2, w_tx_stop2_n, r_tx_par_en, w_tx_par_en_n;
   logic        r_tx_parbit, w_tx_parbit_n, w_txd_n, w_tx_tick;

   // TX state and datapath registers; line output is registered to stay glitch-free.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) begin
         r_tx_state  <= TX_IDLE;
         r_tx_baud   <= '0;
         r_tx_div    <= '0;
         r_tx_shift  <= '0;
         r_tx_bit    <= '0;
         r_tx_stop2  <= 1'b0;
         r_tx_par_en <= 1'b0;
         r_tx_parbit <= 1'b0;
         uart_txd    <= 1'b1;
      end else begin
         r_tx_state  <= w_tx_state_n;
         r_tx_baud   <= w_tx_baud_n;
         r_tx_div    <= w_tx_div_n;
         r_tx_shift  <= w_tx_shift_n;
         r_tx_bit    <= w_tx_bit_n;
         r_tx_stop2  <= w_tx_stop2_n;
         r_tx_par_en <= w_tx_par_en_n;
         r_tx_parbit <= w_tx_parbit_n;
         uart_txd    <= w_txd_n;
      end

   // TX next-state: frame settings are latched at start so mid-frame writes wait a frame.
   always_comb begin
      w_tx_state_n  = r_tx_state;
      w_tx_baud_n   = r_tx_baud;
      w_tx_div_n    = r_tx_div;
      w_tx_shift_n  = r_tx_shift;
      w_tx_bit_n    = r_tx_bit;
      w_tx_stop2_n  = r_tx_stop2;
      w_tx_par_en_n = r_tx_par_en;
      w_tx_parbit_n = r_tx_parbit;
      w_tx_pop      = 1'b0;
      w_tx_tick     = (r_tx_baud == r_tx_div);
      if (r_tx_state != TX_IDLE)
         w_tx_baud_n = w_tx_tick ? '0 : r_tx_baud + 16'd1;
      case (r_tx_state)
         TX_IDLE:
            if (r_txctrl.en && !w_tx_empty) begin
               w_tx_state_n  = TX_START;
               w_tx_pop      = 1'b1;
               w_tx_shift_n  = w_tx_rdata;
               w_tx_div_n    = r_div;
               w_tx_baud_n   = '0;
               w_tx_stop2_n  = r_txctrl.nstop;
               w_tx_par_en_n = par_used(r_txctrl.par);
               w_tx_parbit_n = par_bit(w_tx_rdata, r_txctrl.par);
            end
         TX_START:
            if (w_tx_tick) begin
               w_tx_state_n = TX_DATA;
               w_tx_bit_n   = '0;
            end
         TX_DATA:
            if (w_tx_tick) begin
               w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
               w_tx_bit_n   = r_tx_bit + 3'd1;
               if (r_tx_bit == 3'd7)
                  w_tx_state_n = r_tx_par_en ? TX_PARITY : TX_STOP;
            end
         TX_PARITY:
            if (w_tx_tick) w_tx_state_n = TX_STOP;
         TX_STOP:
            if (w_tx_tick) begin
               if (r_tx_stop2) w_tx_stop2_n = 1'b0;
               else            w_tx_state_n = TX_IDLE;
            end
         default: w_tx_state_n = TX_IDLE;
      endcase
      case (w_tx_state_n)
         TX_START:  w_txd_n = 1'b0;
         TX_DATA:   w_txd_n = w_tx_shift_n[0];
         TX_PARITY: w_txd_n = w_tx_parbit_n;
         default:   w_txd_n = 1'b1;
      endcase
   end

   // ---------------- RX ----------------
   rx_state_e   r_rx_state, w_rx_state_n;
   logic [15:0] r_rx_baud, w_rx_baud_n, r_rx_div, w_rx_div_n, r_rx_half, w_rx_half_n;
   logic [16:0] w_div_p1;
   logic [7:0]  r_rx_shift, w_rx_shift_n;
   logic [2:0]  r_rx_bit, w_rx_bit_n;
   logic        r_rx_par_en, w_rx_par_en_n, r_rx_perr, w_rx_perr_n;
   parity_e     r_rx_par, w_rx_par_n;
   logic        r_rxd_s1, r_rxd_s2, r_rxd_s3, w_rx_fall, w_rx_tick;

   assign w_div_p1  = {1'b0, r_div} + 17'd1;
   assign w_rx_fall = r_rxd_s3 & ~r_rxd_s2;

   // Two-flop synchronizer plus one delay stage for start-edge detection.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) begin
         r_rxd_s1 <= 1'b1;
         r_rxd_s2 <= 1'b1;
         r_rxd_s3 <= 1'b1;
      end else begin
         r_rxd_s1 <= uart_rxd;
         r_rxd_s2 <= r_rxd_s1;
         r_rxd_s3 <= r_rxd_s2;
      end

   // RX state and datapath registers.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) begin
         r_rx_state  <= RX_IDLE;
         r_rx_baud   <= '0;
         r_rx_div    <= '0;
         r_rx_half   <= '0;
         r_rx_shift  <= '0;
         r_rx_bit    <= '0;
         r_rx_par_en <= 1'b0;
         r_rx_par    <= PAR_NONE;
         r_rx_perr   <= 1'b0;
      end else begin
         r_rx_state  <= w_rx_state_n;
         r_rx_baud   <= w_rx_baud_n;
         r_rx_div    <= w_rx_div_n;
         r_rx_half   <= w_rx_half_n;
         r_rx_shift  <= w_rx_shift_n;
         r_rx_bit    <= w_rx_bit_n;
         r_rx_par_en <= w_rx_par_en_n;
         r_rx_par    <= w_rx_par_n;
         r_rx_perr   <= w_rx_perr_n;
      end

   // RX next-state: start bit checked at half period, then every bit sampled mid-period.
   always_comb begin
      w_rx_state_n  = r_rx_state;
      w_rx_baud_n   = r_rx_baud;
      w_rx_div_n    = r_rx_div;
      w_rx_half_n   = r_rx_half;
      w_rx_shift_n  = r_rx_shift;
      w_rx_bit_n    = r_rx_bit;
      w_rx_par_en_n = r_rx_par_en;
      w_rx_par_n    = r_rx_par;
      w_rx_perr_n   = r_rx_perr;
      w_rx_push     = 1'b0;
      w_rx_entry    = '{perr: r_rx_perr, ferr: ~r_rxd_s2, data: r_rx_shift};
      w_rx_tick     = (r_rx_baud == r_rx_div);
      if (r_rx_state != RX_IDLE)
         w_rx_baud_n = w_rx_tick ? '0 : r_rx_baud + 16'd1;
      case (r_rx_state)
         RX_IDLE:
            if (r_rxctrl.en && w_rx_fall) begin
               w_rx_state_n  = RX_START;
               w_rx_baud_n   = '0;
               w_rx_div_n    = r_div;
               w_rx_half_n   = w_div_p1[16:1];
               w_rx_par_en_n = par_used(r_rxctrl.par);
               w_rx_par_n    = r_rxctrl.par;
               w_rx_perr_n   = 1'b0;
            end
         RX_START:
            if (r_rx_baud == r_rx_half) begin
               w_rx_baud_n = '0;
               if (r_rxd_s2) w_rx_state_n = RX_IDLE;
               else begin
                  w_rx_state_n = RX_DATA;
                  w_rx_bit_n   = '0;
               end
            end
         RX_DATA:
            if (w_rx_tick) begin
               w_rx_shift_n = {r_rxd_s2, r_rx_shift[7:1]};
               w_rx_bit_n   = r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7)
                  w_rx_state_n = r_rx_par_en ? RX_PARITY : RX_STOP;
            end
         RX_PARITY:
            if (w_rx_tick) begin
               w_rx_perr_n  = (r_rxd_s2 != par_bit(r_rx_shift, r_rx_par));
               w_rx_state_n = RX_STOP;
            end
         RX_STOP:
            if (w_rx_tick) begin
               w_rx_push    = 1'b1;
               w_rx_state_n = RX_IDLE;
            end
         default: w_rx_state_n = RX_IDLE;
      endcase
      if (!r_rxctrl.en) begin
         w_rx_state_n = RX_IDLE;
         w_rx_push    = 1'b0;
      end
   end

endmodule

// File: tb/tb_apb_uart_par.sv
// Directed bench for apb_uart_par: reset values, loopback, parity error,
// RX overrun, start-glitch rejection, framing error, slave errors, reset mid-frame.
module tb_apb_uart_par;
   import apb_uart_par_pkg::*;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        psel, penable, pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr, txd, rxd, o_txwm, o_rxwm, o_rxerr;
   logic        loop_en, rxd_drv;
   int          total = 0;
   int          bad   = 0;

   assign rxd = loop_en ? txd : rxd_drv;

   always #5 clk = ~clk;

   apb_uart_par #(.FIFO_DEPTH(8), .DIV_RST(16'd868)) dut (
      .clk(clk), .rst_b(rst_b), .apb_psel(psel), .apb_penable(penable),
      .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata),
      .apb_prdata(prdata), .apb_pready(pready), .apb_pslverr(pslverr),
      .uart_txd(txd), .uart_rxd(rxd), .txwm(o_txwm), .rxwm(o_rxwm), .rxerr(o_rxerr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
      @(negedge clk);
      psel = 1'b1; pwrite = wr; paddr = a; pwdata = wd; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1;
      rd  = prdata;
      err = pslverr;
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      logic [31:0] r;
      logic        e;
      xfer(1'b1, a, d, r, e);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      logic e;
      xfer(1'b0, a, 32'h0, d, e);
   endtask

   // Bit-bang one frame on rxd: start, 8 data LSB first, one stop bit of given level.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd_drv = bits[i];
         repeat (87) @(negedge clk);
      end
      rxd_drv = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      logic [7:0]  tx_vec [10];
      int          got, guard;

      tx_vec = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C, 8'h81, 8'h7E, 8'h01, 8'hC3, 8'hEE};
      rst_b = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; loop_en = 1'b1; rxd_drv = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", 32'(txd), 1);
      chk("rst_irq", {29'b0, o_rxerr, o_rxwm, o_txwm}, 0);
      chk("rst_prdata", prdata, 0);
      chk("rst_pslverr", 32'(pslverr), 0);
      chk("pready", 32'(pready), 1);
      @(negedge clk) rst_b = 1'b0;
      rd(ADDR_DIV, d);    chk("rst_div", d, 32'd868);
      rd(ADDR_TXCTRL, d); chk("rst_txctrl", d, 0);
      rd(ADDR_RXCTRL, d); chk("rst_rxctrl", d, 0);
      rd(ADDR_IE, d);     chk("rst_ie", d, 0);
      rd(ADDR_IP, d);     chk("rst_ip", d, 0);
      rd(ADDR_RXDATA, d); chk("rst_rxdata", d, 32'h8000_0000);
      rd(ADDR_TXDATA, d); chk("rst_txdata", d, 0);

      // Loopback, no parity, watermarks 4
      wr(ADDR_DIV, 32'd86);
      wr(ADDR_RXCTRL, 32'h0004_0001);
      wr(ADDR_TXCTRL, 32'h0004_0001);
      for (int i = 0; i < 10; i++) begin
         wr(ADDR_TXDATA, {24'h0, tx_vec[i]});
         if (i == 3) begin rd(ADDR_IP, d); chk("txwm_4_written", 32'(d[0]), 1); end
         if (i == 4) begin rd(ADDR_IP, d); chk("txwm_5_written", 32'(d[0]), 0); end
         if (i == 8) begin rd(ADDR_TXDATA, d); chk("tx_full_8_queued", d, 32'h8000_0000); end
      end
      got = 0; guard = 0;
      while (got < 9 && guard < 6000) begin
         rd(ADDR_RXDATA, d);
         if (!d[31]) begin
            chk($sformatf("lb_byte%0d", got), d, {24'h0, tx_vec[got]});
            got++;
         end
         guard++;
      end
      chk("lb_count", 32'(got), 9);
      repeat (1200) @(posedge clk);
      rd(ADDR_RXDATA, d); chk("lb_full_write_dropped", d, 32'h8000_0000);
      rd(ADDR_IP, d);     chk("lb_no_rxerr", 32'(d[2]), 0);

      // TX even parity, RX odd parity -> parity error
      wr(ADDR_TXCTRL, 32'h0000_0005);
      wr(ADDR_RXCTRL, 32'h0000_0009);
      wr(ADDR_IE, 32'h4);
      wr(ADDR_TXDATA, 32'hA5);
      repeat (1200) @(posedge clk);
      rd(ADDR_RXDATA, d); chk("par_rxdata", d, 32'h4000_00A5);
      rd(ADDR_IP, d);     chk("par_ip", d, 32'h4);
      chk("par_irq_out", 32'(o_rxerr), 1);
      wr(ADDR_IP, 32'h4);
      rd(ADDR_IP, d);     chk("par_w1c_ip", d, 0);
      chk("par_w1c_irq", 32'(o_rxerr), 0);

      // RX overrun: 9 bytes, never read while arriving
      wr(ADDR_IE, 32'h0);
      wr(ADDR_RXCTRL, 32'h0007_0001);
      wr(ADDR_TXCTRL, 32'h0000_0001);
      for (int i = 0; i < 9; i++) wr(ADDR_TXDATA, 32'h10 + 32'(i));
      repeat (8300) @(posedge clk);
      rd(ADDR_IP, d); chk("ovf_ip_full_err", d, 32'h6);
      for (int i = 0; i < 8; i++) begin
         rd(ADDR_RXDATA, d);
         chk($sformatf("ovf_byte%0d", i), d, 32'h10 + 32'(i));
      end
      rd(ADDR_RXDATA, d); chk("ovf_only8", d, 32'h8000_0000);

      // Short start glitch, then a frame with a low stop bit
      wr(ADDR_TXCTRL, 32'h0);
      wr(ADDR_RXCTRL, 32'h1);
      wr(ADDR_IP, 32'h4);
      @(negedge clk); rxd_drv = 1'b1; loop_en = 1'b0;
      @(negedge clk); rxd_drv = 1'b0;
      repeat (21) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (200) @(posedge clk);
      rd(ADDR_RXDATA, d); chk("glitch_nopush", d, 32'h8000_0000);
      rd(ADDR_IP, d);     chk("glitch_ip", d, 0);
      send_frame(8'h3C, 1'b0);
      repeat (100) @(posedge clk);
      rd(ADDR_RXDATA, d); chk("ferr_rxdata", d, 32'h2000_003C);
      rd(ADDR_IP, d);     chk("ferr_ip", d, 32'h4);
      loop_en = 1'b1;

      // Slave errors leave state untouched
      wr(ADDR_IP, 32'h4);
      wr(ADDR_TXCTRL, 32'h0001_0000);
      xfer(1'b1, 5'h1C, 32'hFFFF_FFFF, d, e); chk("err_wr_1c", 32'(e), 1);
      xfer(1'b1, 5'h02, 32'h0000_0041, d, e); chk("err_wr_02", 32'(e), 1);
      xfer(1'b1, 5'h1A, 32'h0000_1234, d, e); chk("err_wr_1a", 32'(e), 1);
      xfer(1'b0, 5'h1C, 32'h0, d, e);
      chk("err_rd_1c", 32'(e), 1);
      chk("err_rd_1c_data", d, 0);
      xfer(1'b0, ADDR_DIV, 32'h0, d, e);
      chk("ok_rd_div_err", 32'(e), 0);
      chk("err_div_kept", d, 32'd86);
      rd(ADDR_IP, d);     chk("err_no_push", d, 32'h1);
      rd(ADDR_TXCTRL, d); chk("err_txctrl_kept", d, 32'h0001_0000);

      // Reset in the middle of a TX frame
      wr(ADDR_IE, 32'h7);
      wr(ADDR_TXCTRL, 32'h1);
      wr(ADDR_TXDATA, 32'h00);
      repeat (300) @(negedge clk);
      chk("txd_midframe_low", 32'(txd), 0);
      rst_b = 1'b1;
      #1;
      chk("txd_async_reset", 32'(txd), 1);
      @(negedge clk) rst_b = 1'b0;
      chk("post_rst_irq", {29'b0, o_rxerr, o_rxwm, o_txwm}, 0);
      rd(ADDR_DIV, d);    chk("post_rst_div", d, 32'd868);
      rd(ADDR_TXCTRL, d); chk("post_rst_txctrl", d, 0);
      rd(ADDR_RXCTRL, d); chk("post_rst_rxctrl", d, 0);
      rd(ADDR_IE, d);     chk("post_rst_ie", d, 0);
      rd(ADDR_IP, d);     chk("post_rst_ip", d, 0);
      rd(ADDR_RXDATA, d); chk("post_rst_rxdata", d, 32'h8000_0000);
      rd(ADDR_TXDATA, d); chk("post_rst_txdata", d, 0);
      repeat (20) @(negedge clk);
      chk("post_rst_txd_idle", 32'(txd), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
